// File: rtl/alu_seq_core.sv
// alu_seq_core: handshaked, operand-registered ALU with {shift,ainv,bneg,aluop}
// opcodes. The result and flags are held until the consumer takes them.
// Optional feature macro ALU_SHIFT_EN: when defined, adds an iterative
// one-bit-per-cycle shifter (SLL/SRL/SRA). When it is undefined, every shift code
// is reported as illegal.
module alu_seq_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             negative,
  output logic             illegal
);

`ifdef ALU_SHIFT_EN
  // The shift amount width is derived from WIDTH.
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_r, b_r;
  logic [4:0]       op_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r, carry_r, ovf_r, neg_r, illegal_r;
  logic             out_valid_r, in_ready_r;

  logic [WIDTH-1:0] a_p_s, b_p_s;
  logic [WIDTH:0]   sum_s;
  logic             sum_ovf_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_cout_s, alu_ovf_s;
  logic             ill_s;
  logic [WIDTH-1:0] fin_res_s;
  logic             fin_cout_s, fin_ovf_s;
  logic             load_s;

`ifdef ALU_SHIFT_EN
  logic [SHW-1:0]   cnt_r;
  logic [WIDTH-1:0] sh_r, sh_next_s;
  logic             sh_bit_s;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign zero      = zero_r;
  assign carry_out = carry_r;
  assign overflow  = ovf_r;
  assign negative  = neg_r;
  assign illegal   = illegal_r;

  // Logic-unit and adder datapath for the non-shift operations.
  always_comb begin
    a_p_s      = op_r[3] ? ~a_r : a_r;
    b_p_s      = op_r[2] ? ~b_r : b_r;
    sum_s      = {1'b0, a_p_s} + {1'b0, b_p_s} + {{WIDTH{1'b0}}, op_r[2]};
    sum_ovf_s  = (a_p_s[WIDTH-1] == b_p_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_p_s[WIDTH-1]);
    alu_res_s  = {WIDTH{1'b0}};
    alu_cout_s = 1'b0;
    alu_ovf_s  = 1'b0;
    case (op_r[1:0])
      2'b00: alu_res_s = a_p_s & b_p_s;
      2'b01: alu_res_s = a_p_s | b_p_s;
      2'b10: begin
        alu_res_s  = sum_s[WIDTH-1:0];
        alu_cout_s = sum_s[WIDTH];
        alu_ovf_s  = sum_ovf_s;
      end
      2'b11: begin
        alu_res_s  = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ sum_ovf_s};
        alu_cout_s = sum_s[WIDTH];
        alu_ovf_s  = sum_ovf_s;
      end
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Decode which latched opcodes are not supported in this build.
  always_comb begin
    ill_s = 1'b0;
`ifdef ALU_SHIFT_EN
    if (op_r[4] && (op_r[1:0] == 2'b11)) begin
      ill_s = 1'b1;
    end else begin
      ill_s = 1'b0;
    end
`else
    if (op_r[4]) begin
      ill_s = 1'b1;
    end else begin
      ill_s = 1'b0;
    end
`endif
  end

`ifdef ALU_SHIFT_EN
  // One-bit shift step with the bit that falls off the end.
  always_comb begin
    sh_next_s = sh_r;
    sh_bit_s  = 1'b0;
    case (op_r[1:0])
      2'b00: begin
        sh_next_s = {sh_r[WIDTH-2:0], 1'b0};
        sh_bit_s  = sh_r[WIDTH-1];
      end
      2'b01: begin
        sh_next_s = {1'b0, sh_r[WIDTH-1:1]};
        sh_bit_s  = sh_r[0];
      end
      2'b10: begin
        sh_next_s = {sh_r[WIDTH-1], sh_r[WIDTH-1:1]};
        sh_bit_s  = sh_r[0];
      end
      default: begin
        sh_next_s = sh_r;
        sh_bit_s  = 1'b0;
      end
    endcase
  end
`endif

  // Select the value captured into the output registers on entry to DONE.
  always_comb begin
    fin_res_s  = alu_res_s;
    fin_cout_s = alu_cout_s;
    fin_ovf_s  = alu_ovf_s;
    if (ill_s) begin
      fin_res_s  = {WIDTH{1'b0}};
      fin_cout_s = 1'b0;
      fin_ovf_s  = 1'b0;
    end
`ifdef ALU_SHIFT_EN
    else if (op_r[4]) begin
      fin_ovf_s = 1'b0;
      if (state_r == SHIFT) begin
        fin_res_s  = sh_next_s;
        fin_cout_s = sh_bit_s;
      end else begin
        // A zero shift amount passes A through; no bit is shifted out.
        fin_res_s  = a_r;
        fin_cout_s = 1'b0;
      end
    end
`endif
    else begin
      fin_res_s  = alu_res_s;
      fin_cout_s = alu_cout_s;
      fin_ovf_s  = alu_ovf_s;
    end
  end

  // Next-state logic; load_s marks the cycle whose result enters DONE.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
`ifdef ALU_SHIFT_EN
        if (op_r[4] && !ill_s && (b_r[SHW-1:0] != CNT_ZERO)) begin
          state_s = SHIFT;
        end else begin
          state_s = DONE;
          load_s  = 1'b1;
        end
`else
        state_s = DONE;
        load_s  = 1'b1;
`endif
      end
`ifdef ALU_SHIFT_EN
      SHIFT: begin
        if (cnt_r == CNT_ONE) begin
          state_s = DONE;
          load_s  = 1'b1;
        end else begin
          state_s = SHIFT;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Capture the request only when the core is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r  <= {WIDTH{1'b0}};
      b_r  <= {WIDTH{1'b0}};
      op_r <= 5'd0;
    end else if ((state_r == IDLE) && in_valid) begin
      a_r  <= a;
      b_r  <= b;
      op_r <= op;
    end
  end

`ifdef ALU_SHIFT_EN
  // The shift working register and down-counter are loaded in EXEC and stepped in SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_r  <= {WIDTH{1'b0}};
      cnt_r <= CNT_ZERO;
    end else if (state_r == EXEC) begin
      sh_r  <= a_r;
      cnt_r <= b_r[SHW-1:0];
    end else if (state_r == SHIFT) begin
      sh_r  <= sh_next_s;
      cnt_r <= cnt_r - CNT_ONE;
    end
  end
`endif

  // Registered handshake, result and flags; the result holds until the next op completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r    <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      carry_r     <= 1'b0;
      ovf_r       <= 1'b0;
      neg_r       <= 1'b0;
      illegal_r   <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      out_valid_r <= (state_s == DONE);
      in_ready_r  <= (state_s == IDLE);
      if (load_s) begin
        result_r  <= fin_res_s;
        zero_r    <= (fin_res_s == {WIDTH{1'b0}});
        carry_r   <= fin_cout_s;
        ovf_r     <= fin_ovf_s;
        neg_r     <= fin_res_s[WIDTH-1];
        illegal_r <= ill_s;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed-vector bench for alu_seq_core with a 16-bit and a
// 32-bit instance. The shift cases are selected by ALU_SHIFT_EN to match the build.
module tb_alu_seq_core;

  logic clk = 1'b0;
  logic rst_n;

  logic        iv16, ir16, ov16, or16, z16, c16, o16, n16, il16;
  logic [15:0] a16, b16, r16;
  logic [4:0]  op16;

  logic        iv32, ir32, ov32, or32, z32, c32, o32, n32, il32;
  logic [31:0] a32, b32, r32;
  logic [4:0]  op32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq_core #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .op(op16), .out_valid(ov16), .out_ready(or16), .result(r16), .zero(z16),
    .carry_out(c16), .overflow(o16), .negative(n16), .illegal(il16)
  );

  alu_seq_core #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .op(op32), .out_valid(ov32), .out_ready(or32), .result(r32), .zero(z32),
    .carry_out(c32), .overflow(o32), .negative(n32), .illegal(il32)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ov(input bit w32);
    return w32 ? ov32 : ov16;
  endfunction

  function automatic logic get_ir(input bit w32);
    return w32 ? ir32 : ir16;
  endfunction

  function automatic logic [63:0] get_res(input bit w32);
    return w32 ? {32'd0, r32} : {48'd0, r16};
  endfunction

  // Flags packed as {illegal, zero, carry_out, overflow, negative}.
  function automatic logic [63:0] get_flg(input bit w32);
    return w32 ? {59'd0, il32, z32, c32, o32, n32} : {59'd0, il16, z16, c16, o16, n16};
  endfunction

  // Issue one request with out_ready held high, check latency, result, flags and the return to IDLE.
  task automatic run_op(input string tag, input bit w32, input logic [63:0] av,
                        input logic [63:0] bv, input logic [4:0] opv, input int exp_lat,
                        input logic [63:0] exp_res, input logic [4:0] exp_flg);
    int n;
    if (w32) begin
      a32 = av[31:0]; b32 = bv[31:0]; op32 = opv; iv32 = 1'b1;
    end else begin
      a16 = av[15:0]; b16 = bv[15:0]; op16 = opv; iv16 = 1'b1;
    end
    @(posedge clk); #1;
    iv16 = 1'b0;
    iv32 = 1'b0;
    n = 1;
    while (!get_ov(w32) && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check_val({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check_val({tag, "_res"}, get_res(w32), exp_res);
    check_val({tag, "_flg"}, get_flg(w32), {59'd0, exp_flg});
    @(posedge clk); #1;
    check_val({tag, "_ovdrop"}, {63'd0, get_ov(w32)}, 64'd0);
    check_val({tag, "_irdy"}, {63'd0, get_ir(w32)}, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    iv16 = 1'b0; a16 = 16'd0; b16 = 16'd0; op16 = 5'd0; or16 = 1'b1;
    iv32 = 1'b0; a32 = 32'd0; b32 = 32'd0; op32 = 5'd0; or32 = 1'b1;
    #12;
    check_val("rst_irdy16", {63'd0, ir16}, 64'd1);
    check_val("rst_ov16", {63'd0, ov16}, 64'd0);
    check_val("rst_res16", {48'd0, r16}, 64'd0);
    check_val("rst_flg16", get_flg(1'b0), 64'd0);
    check_val("rst_irdy32", {63'd0, ir32}, 64'd1);
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Arithmetic and logic vectors (flags {ill,zero,cout,ovf,neg}).
    run_op("add_ovf", 1'b0, 64'h7FFF, 64'h0001, 5'b00010, 2, 64'h8000, 5'b00011);
    run_op("sub_eq",  1'b0, 64'h1234, 64'h1234, 5'b00110, 2, 64'h0000, 5'b01100);
    run_op("slt_ovf", 1'b0, 64'h8000, 64'h0001, 5'b00111, 2, 64'h0001, 5'b00110);
    run_op("slt_pos", 1'b0, 64'h0001, 64'h0002, 5'b00111, 2, 64'h0001, 5'b00000);
    run_op("sub_neg", 1'b0, 64'h0001, 64'h0002, 5'b00110, 2, 64'hFFFF, 5'b00001);
    run_op("sub_min", 1'b0, 64'h8000, 64'h0001, 5'b00110, 2, 64'h7FFF, 5'b00110);
    run_op("add_cy",  1'b0, 64'hFFFF, 64'h0001, 5'b00010, 2, 64'h0000, 5'b01100);
    run_op("or",      1'b0, 64'h00F0, 64'h0F00, 5'b00001, 2, 64'h0FF0, 5'b00000);
    run_op("andinv",  1'b0, 64'hFF00, 64'h0FF0, 5'b01000, 2, 64'h00F0, 5'b00000);

`ifdef ALU_SHIFT_EN
    run_op("sra4",    1'b0, 64'h8001, 64'h0004, 5'b10010, 6,  64'hF800, 5'b00001);
    run_op("sra0",    1'b0, 64'h8001, 64'h0000, 5'b10010, 2,  64'h8001, 5'b00001);
    run_op("sll15",   1'b0, 64'h0001, 64'h000F, 5'b10000, 17, 64'h8000, 5'b00001);
    run_op("srl1",    1'b0, 64'h0003, 64'h0001, 5'b10001, 3,  64'h0001, 5'b00100);
    run_op("sh_ill",  1'b0, 64'h1234, 64'h0003, 5'b10011, 2,  64'h0000, 5'b11000);
`else
    run_op("sll_ill", 1'b0, 64'h1234, 64'h0003, 5'b10000, 2, 64'h0000, 5'b11000);
    run_op("sra_ill", 1'b0, 64'h8001, 64'h0004, 5'b10010, 2, 64'h0000, 5'b11000);
`endif

    // Backpressure: DONE held for 5 cycles while a new request waits on in_valid.
    a16 = 16'hF0F0; b16 = 16'hFF00; op16 = 5'b00000; iv16 = 1'b1; or16 = 1'b0;
    @(posedge clk); #1;
    a16 = 16'h1111; b16 = 16'h0220; op16 = 5'b00001;
    n = 1;
    while (!ov16 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("bp_lat", 64'(n), 64'd2);
    for (int i = 0; i < 5; i++) begin
      check_val("bp_res", {48'd0, r16}, 64'hF000);
      check_val("bp_irdy", {63'd0, ir16}, 64'd0);
      check_val("bp_ov", {63'd0, ov16}, 64'd1);
      @(posedge clk); #1;
    end
    or16 = 1'b1;
    @(posedge clk); #1;
    check_val("bp_rel_ov", {63'd0, ov16}, 64'd0);
    check_val("bp_rel_irdy", {63'd0, ir16}, 64'd1);
    check_val("bp_rel_res", {48'd0, r16}, 64'hF000);
    // The held request is taken at this edge.
    @(posedge clk); #1;
    iv16 = 1'b0;
    n = 1;
    while (!ov16 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("bp2_lat", 64'(n), 64'd2);
    check_val("bp2_res", {48'd0, r16}, 64'h1331);
    @(posedge clk); #1;

    // Reset in the middle of an operation discards it.
`ifdef ALU_SHIFT_EN
    a16 = 16'h0001; b16 = 16'd12; op16 = 5'b10000; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`else
    a16 = 16'h0001; b16 = 16'd12; op16 = 5'b00010; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
`endif
    check_val("mid_irdy", {63'd0, ir16}, 64'd0);
    rst_n = 1'b0;
    #1;
    check_val("mrst_ov", {63'd0, ov16}, 64'd0);
    check_val("mrst_res", {48'd0, r16}, 64'd0);
    check_val("mrst_irdy", {63'd0, ir16}, 64'd1);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("post_ov", {63'd0, ov16}, 64'd0);
    check_val("post_irdy", {63'd0, ir16}, 64'd1);
    run_op("nor", 1'b0, 64'h0000, 64'h0000, 5'b01100, 2, 64'hFFFF, 5'b00001);

    // 32-bit instance.
    run_op("add32", 1'b1, 64'hFFFF_FFFF, 64'h1, 5'b00010, 2, 64'h0, 5'b01100);
    run_op("sub32", 1'b1, 64'h8000_0000, 64'h1, 5'b00110, 2, 64'h7FFF_FFFF, 5'b00110);
`ifdef ALU_SHIFT_EN
    run_op("srl32", 1'b1, 64'h8000_0000, 64'd31, 5'b10001, 33, 64'h1, 5'b00000);
`else
    run_op("ill32", 1'b1, 64'h1234_5678, 64'h1, 5'b10000, 2, 64'h0, 5'b11000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
